paillier_enc_ctrl: RTL and testbench



---
 rtl/paillier_enc_ctrl.sv | 139 +++++++++++++
 tb/tb_paillier_enc_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paillier_enc_ctrl.sv
// Paillier encryption sequencer: drives exponentiation, noise multiplication and Montgomery
// conversion on a shared modexp unit, one ciphertext in flight at a time.
module paillier_enc_ctrl #(
  parameter int unsigned N2_length     = 512,
  parameter int unsigned data_length   = 32,
  localparam int unsigned W            = N2_length + 16,
  // Montgomery form of g = N+1; set to the modulus-specific constant at instantiation.
  parameter logic [W-1:0] N_plus_1_mont = W'(64'hA613_5C2E_9D04_3BDF),
  parameter int unsigned FLUSH_CYCLES  = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [data_length-1:0] plaintext_i,
  input  logic [W-1:0]           noise_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [W-1:0]           ciphertext_o,
  output logic [15:0]            enc_count_o,
  output logic                   mx_start_o,
  output logic                   mx_task_o,
  output logic [W-1:0]           mx_base_o,
  output logic [W-1:0]           mx_exponent_o,
  input  logic                   mx_done_i,
  input  logic [W-1:0]           mx_power_i
);

  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES) + 1;

  typedef enum logic [3:0] {
    StFlush, StIdle, StExpStart, StExpWait, StMulStart, StMulWait, StConvStart, StConvWait, StOut
  } state_e;

  state_e              state_q, state_d;
  logic [FlushW-1:0]   flush_q, flush_d;
  logic [W-1:0]        noise_q, noise_d;
  logic [W-1:0]        ct_q, ct_d;
  logic [W-1:0]        base_q, base_d;
  logic [W-1:0]        exp_q, exp_d;
  logic                task_q, task_d;
  logic [15:0]         cnt_q, cnt_d;

  // Operand registers are loaded on entry to each START state; base_q doubles as the accumulator.
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    noise_d = noise_q;
    ct_d    = ct_q;
    base_d  = base_q;
    exp_d   = exp_q;
    task_d  = task_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFlush: begin
        if (flush_q == FlushW'(FLUSH_CYCLES - 1)) begin
          flush_d = '0;
          state_d = StIdle;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      StIdle: begin
        if (in_valid_i) begin
          noise_d = noise_i;
          base_d  = N_plus_1_mont;
          exp_d   = W'(plaintext_i);
          task_d  = 1'b0;
          state_d = StExpStart;
        end
      end
      StExpStart: state_d = StExpWait;
      StExpWait: begin
        if (mx_done_i) begin
          base_d  = mx_power_i;
          exp_d   = noise_q;
          task_d  = 1'b1;
          state_d = StMulStart;
        end
      end
      StMulStart: state_d = StMulWait;
      StMulWait: begin
        if (mx_done_i) begin
          base_d  = mx_power_i;
          exp_d   = W'(1);
          task_d  = 1'b1;
          state_d = StConvStart;
        end
      end
      StConvStart: state_d = StConvWait;
      StConvWait: begin
        if (mx_done_i) begin
          ct_d    = mx_power_i;
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StFlush;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFlush;
      flush_q <= '0;
      noise_q <= '0;
      ct_q    <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      task_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      noise_q <= noise_d;
      ct_q    <= ct_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      task_q  <= task_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o    = (state_q == StIdle);
  assign out_valid_o   = (state_q == StOut);
  assign mx_start_o    = (state_q == StExpStart) || (state_q == StMulStart) ||
                         (state_q == StConvStart);
  assign mx_task_o     = task_q;
  assign mx_base_o     = base_q;
  assign mx_exponent_o = exp_q;
  assign ciphertext_o  = ct_q;
  assign enc_count_o   = cnt_q;

endmodule

// File: tb/tb_paillier_enc_ctrl.sv
// Self-checking bench for paillier_enc_ctrl with a latency-programmable exponentiator model.
module tb_paillier_enc_ctrl;

  localparam int unsigned NL = 512;
  localparam int unsigned DL = 32;
  localparam int unsigned W  = NL + 16;
  localparam int unsigned FL = 16;
  localparam logic [W-1:0] NP1 = W'(96'hA613_5C2E_9D04_77B1_3BDF);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [DL-1:0]  plaintext_i;
  logic [W-1:0]   noise_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [W-1:0]   ciphertext_o;
  logic [15:0]    enc_count_o;
  logic           mx_start_o;
  logic           mx_task_o;
  logic [W-1:0]   mx_base_o;
  logic [W-1:0]   mx_exponent_o;
  logic           mx_done_i;
  logic [W-1:0]   mx_power_i;

  logic           rsp_done;
  logic [W-1:0]   rsp_pw;
  logic           spur_done;
  logic [W-1:0]   spur_pw;
  logic [W-1:0]   pw_q [$];
  int             lat;
  int             n_cmp;
  int             n_err;
  logic [15:0]    exp_count;

  assign mx_done_i  = rsp_done | spur_done;
  assign mx_power_i = spur_done ? spur_pw : rsp_pw;

  paillier_enc_ctrl #(
    .N2_length     (NL),
    .data_length   (DL),
    .N_plus_1_mont (NP1),
    .FLUSH_CYCLES  (FL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .plaintext_i   (plaintext_i),
    .noise_i       (noise_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .ciphertext_o  (ciphertext_o),
    .enc_count_o   (enc_count_o),
    .mx_start_o    (mx_start_o),
    .mx_task_o     (mx_task_o),
    .mx_base_o     (mx_base_o),
    .mx_exponent_o (mx_exponent_o),
    .mx_done_i     (mx_done_i),
    .mx_power_i    (mx_power_i)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom());
    return v;
  endfunction

  // Exponentiator model: mx_done exactly lat cycles after each observed mx_start, random result.
  initial begin
    rsp_done = 1'b0;
    rsp_pw   = '0;
    forever begin
      @(posedge clk); #1;
      while (mx_start_o === 1'b1) begin
        repeat (lat) @(posedge clk);
        #1;
        rsp_pw   = rand_w();
        rsp_done = 1'b1;
        pw_q.push_back(rsp_pw);
        @(posedge clk); #1;
        rsp_done = 1'b0;
        rsp_pw   = '0;
      end
    end
  end

  task automatic run_enc(input logic [DL-1:0] m, input logic [W-1:0] nz, input int bp,
                         input bit spur_start, input string tag);
    int t, ns, ov_cyc;
    bit got, seen_rdy;
    int s_cyc [3];
    logic s_task [3];
    logic [W-1:0] s_base [3];
    logic [W-1:0] s_exp [3];
    int e_cyc [3];
    logic e_task [3];
    logic [W-1:0] e_base [3];
    logic [W-1:0] e_exp [3];
    logic [W-1:0] ct;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready_o === 1'b1) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s accept_wait: in_ready=%b want 1", tag, in_ready_o);
      return;
    end
    pw_q.delete();
    plaintext_i = m;
    noise_i     = nz;
    in_valid_i  = 1'b1;
    @(posedge clk); #1;
    in_valid_i  = 1'b0;
    plaintext_i = $urandom();
    noise_i     = rand_w();
    if (spur_start) begin
      spur_pw   = rand_w();
      spur_done = 1'b1;
    end
    t = 1; ns = 0; ov_cyc = -1; seen_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      s_cyc[i] = -1; s_task[i] = 1'bx; s_base[i] = 'x; s_exp[i] = 'x;
    end
    while (ov_cyc < 0 && t <= 3 * lat + 20) begin
      if (t == 2) spur_done = 1'b0;
      if (in_ready_o === 1'b1) seen_rdy = 1;
      if (mx_start_o === 1'b1) begin
        if (ns < 3) begin
          s_cyc[ns] = t; s_task[ns] = mx_task_o; s_base[ns] = mx_base_o; s_exp[ns] = mx_exponent_o;
        end
        ns++;
      end
      if (out_valid_o === 1'b1) ov_cyc = t;
      else begin
        @(posedge clk); #1;
        t++;
      end
    end
    spur_done = 1'b0;

    // Reference: exp(g,m), mul(prev,noise), mul(prev,1) with start cycles at 1, L+2, 2L+3.
    e_cyc[0] = 1; e_cyc[1] = lat + 2; e_cyc[2] = 2 * lat + 3;
    e_task[0] = 1'b0; e_task[1] = 1'b1; e_task[2] = 1'b1;
    e_exp[0] = W'(m); e_exp[1] = nz; e_exp[2] = W'(1);
    e_base[0] = NP1;
    e_base[1] = (pw_q.size() > 0) ? pw_q[0] : 'x;
    e_base[2] = (pw_q.size() > 1) ? pw_q[1] : 'x;
    ct        = (pw_q.size() > 2) ? pw_q[2] : 'x;

    n_cmp++;
    if (ns !== 3) begin
      n_err++;
      $display("FAIL %s start_count: got %0d want 3", tag, ns);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (s_cyc[i] !== e_cyc[i]) begin
        n_err++;
        $display("FAIL %s start%0d_cycle: got %0d want %0d", tag, i, s_cyc[i], e_cyc[i]);
      end
      n_cmp++;
      if (s_task[i] !== e_task[i]) begin
        n_err++;
        $display("FAIL %s start%0d_task: got %b want %b", tag, i, s_task[i], e_task[i]);
      end
      n_cmp++;
      if (s_base[i] !== e_base[i]) begin
        n_err++;
        $display("FAIL %s start%0d_base: got %h want %h", tag, i, s_base[i], e_base[i]);
      end
      n_cmp++;
      if (s_exp[i] !== e_exp[i]) begin
        n_err++;
        $display("FAIL %s start%0d_exp: got %h want %h", tag, i, s_exp[i], e_exp[i]);
      end
    end
    n_cmp++;
    if (seen_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_ready: in_ready seen %b want 0", tag, seen_rdy);
    end
    n_cmp++;
    if (ov_cyc !== 3 * lat + 4) begin
      n_err++;
      $display("FAIL %s out_valid_cycle: got %0d want %0d", tag, ov_cyc, 3 * lat + 4);
    end
    if (ov_cyc < 0) return;
    n_cmp++;
    if (ciphertext_o !== ct) begin
      n_err++;
      $display("FAIL %s ciphertext: got %h want %h", tag, ciphertext_o, ct);
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || ciphertext_o !== ct ||
          enc_count_o !== exp_count) begin
        n_err++;
        $display("FAIL %s backpressure@%0d: ov=%b rdy=%b cnt=%h ct_ok=%b want ov=1 rdy=0 cnt=%h",
                 tag, i, out_valid_o, in_ready_o, enc_count_o, ciphertext_o === ct, exp_count);
      end
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    exp_count++;
    n_cmp++;
    if (enc_count_o !== exp_count) begin
      n_err++;
      $display("FAIL %s enc_count: got %h want %h", tag, enc_count_o, exp_count);
    end
    n_cmp++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s post_handshake: ov=%b rdy=%b want ov=0 rdy=1", tag, out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_reset();
    int first;
    bit st_seen, ov_seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o, mx_start_o, mx_task_o, enc_count_o} !== '0 ||
        ciphertext_o !== '0 || mx_base_o !== '0 || mx_exponent_o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b ov=%b st=%b tk=%b cnt=%h ct=%0h base=%0h exp=%0h want 0",
               in_ready_o, out_valid_o, mx_start_o, mx_task_o, enc_count_o, ciphertext_o,
               mx_base_o, mx_exponent_o);
    end
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    first = -1; st_seen = 0; ov_seen = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (in_ready_o === 1'b1 && first < 0) first = c;
      if (mx_start_o === 1'b1) st_seen = 1;
      if (out_valid_o === 1'b1) ov_seen = 1;
      spur_pw   = rand_w();
      spur_done = (c < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    spur_done = 1'b0;
    n_cmp++;
    if (first !== int'(FL)) begin
      n_err++;
      $display("FAIL flush_ready_cycle: got %0d want %0d", first, FL);
    end
    n_cmp++;
    if (st_seen !== 1'b0 || ov_seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_activity: start=%b out_valid=%b want 0 0", st_seen, ov_seen);
    end
    n_cmp++;
    if (ciphertext_o !== '0 || mx_base_o !== '0 || mx_exponent_o !== '0) begin
      n_err++;
      $display("FAIL flush_capture: ct=%0h base=%0h exp=%0h want 0", ciphertext_o, mx_base_o,
               mx_exponent_o);
    end
  endtask

  task automatic test_basic();
    lat = 10;
    run_enc(32'd5, W'(16'h1234), 20, 1'b0, "basic");
  endtask

  task automatic test_spurious();
    logic [W-1:0] ct0, b0;
    lat = 10;
    ct0 = ciphertext_o;
    b0  = mx_base_o;
    spur_pw   = rand_w();
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    n_cmp++;
    if (in_ready_o !== 1'b1 || mx_start_o !== 1'b0) begin
      n_err++;
      $display("FAIL spur_idle_state: rdy=%b st=%b want 1 0", in_ready_o, mx_start_o);
    end
    n_cmp++;
    if (ciphertext_o !== ct0 || mx_base_o !== b0) begin
      n_err++;
      $display("FAIL spur_idle_capture: ct=%h base=%h want ct=%h base=%h", ciphertext_o, mx_base_o,
               ct0, b0);
    end
    run_enc($urandom(), rand_w(), 2, 1'b1, "spur_start");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      lat = $urandom_range(1, 12);
      run_enc($urandom(), rand_w(), $urandom_range(0, 3), 1'b0, "random");
    end
    lat = 10;
    run_enc(32'd0, rand_w(), 0, 1'b0, "m_zero");
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] nz;
    int first;
    bit ov_seen;
    lat = 10;
    for (int i = 0; i < 100 && in_ready_o !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    nz = rand_w();
    plaintext_i = $urandom();
    noise_i     = nz;
    in_valid_i  = 1'b1;
    @(posedge clk); #1;
    in_valid_i  = 1'b0;
    repeat (lat + 4) @(posedge clk);
    #1;
    n_cmp++;
    if (mx_task_o !== 1'b1 || mx_start_o !== 1'b0 || mx_exponent_o !== nz) begin
      n_err++;
      $display("FAIL abort_mul_wait: tk=%b st=%b exp_ok=%b want 1 0 1", mx_task_o, mx_start_o,
               mx_exponent_o === nz);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o, mx_start_o, mx_task_o, enc_count_o} !== '0 ||
        ciphertext_o !== '0 || mx_base_o !== '0 || mx_exponent_o !== '0) begin
      n_err++;
      $display("FAIL abort_reset_outputs: rdy=%b ov=%b st=%b tk=%b cnt=%h want 0", in_ready_o,
               out_valid_o, mx_start_o, mx_task_o, enc_count_o);
    end
    exp_count = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first = -1; ov_seen = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (out_valid_o === 1'b1) ov_seen = 1;
      if (in_ready_o === 1'b1 && first < 0) first = c;
    end
    n_cmp++;
    if (ov_seen !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_output: out_valid seen %b want 0", ov_seen);
    end
    n_cmp++;
    if (first !== int'(FL)) begin
      n_err++;
      $display("FAIL abort_flush_cycle: got %0d want %0d", first, FL);
    end
    run_enc(32'd7, rand_w(), 0, 1'b0, "post_abort");
  endtask

  task automatic test_wrap();
    lat = 1;
    for (int i = 0; i < 100 && in_ready_o !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    force dut.cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.cnt_q;
    exp_count = 16'hFFFF;
    run_enc($urandom(), rand_w(), 1, 1'b0, "wrap");
    run_enc($urandom(), rand_w(), 0, 1'b0, "back_to_back");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; exp_count = '0; lat = 10;
    rst_n = 1'b0;
    in_valid_i = 1'b0; plaintext_i = '0; noise_i = '0; out_ready_i = 1'b0;
    spur_done = 1'b0; spur_pw = '0;
    test_reset();
    test_basic();
    test_spurious();
    test_random();
    test_reset_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
